// File: rtl/fpadd_stream_ctrl.sv
// Streaming wrapper around the single-cycle FP32 adder: issues tagged operand pairs,
// tracks the adder's two-edge latency and buffers sums in a credit-protected result FIFO.
module fpadd_stream_ctrl #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fa_a,
    output logic [31:0]      fa_b,
    input  logic [31:0]      fa_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [15:0]      res_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = PTR_W + 2;
    localparam int ENT_W = 32 + TAG_W;

    logic [31:0]      fa_a_q, fa_a_d, fa_b_q, fa_b_d;
    logic             vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [TAG_W-1:0] tag_p0_q, tag_p0_d, tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      res_count_q, res_count_d;
    logic [ENT_W-1:0] fifo_mem_q [DEPTH];
    logic [ENT_W-1:0] fifo_mem_d [DEPTH];

    logic [CRD_W-1:0] credit_used;
    logic             accept, push, pop;

    // Credits count both stored results and pairs still inside the adder pipeline,
    // so a capture can never find the FIFO full.
    always_comb begin
        credit_used = CRD_W'(count_q) + CRD_W'(vld_p0_q) + CRD_W'(vld_p1_q) + CRD_W'(vld_p2_q);
        in_ready    = credit_used < CRD_W'(DEPTH);
        res_valid   = (count_q != '0);
        accept      = in_valid && in_ready;
        push        = vld_p2_q;
        pop         = res_valid && res_ready;
    end

    always_comb begin
        fa_a_d      = accept ? in_a : 32'h0;
        fa_b_d      = accept ? in_b : 32'h0;
        vld_p0_d    = accept;
        tag_p0_d    = accept ? in_tag : '0;
        // p0 -> p1: adder samples its operand registers
        vld_p1_d    = vld_p0_q;
        tag_p1_d    = tag_p0_q;
        // p1 -> p2: adder output valid
        vld_p2_d    = vld_p1_q;
        tag_p2_d    = tag_p1_q;

        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        res_count_d = push ? res_count_q + 16'd1 : res_count_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {fa_out, tag_p2_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fa_a_q      <= 32'h0;
            fa_b_q      <= 32'h0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            tag_p0_q    <= '0;
            tag_p1_q    <= '0;
            tag_p2_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_count_q <= 16'h0;
        end else begin
            fa_a_q      <= fa_a_d;
            fa_b_q      <= fa_b_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            tag_p0_q    <= tag_p0_d;
            tag_p1_q    <= tag_p1_d;
            tag_p2_q    <= tag_p2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_count_q <= res_count_d;
        end
    end

    // Storage is not reset; stale entries are hidden while the FIFO is empty.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_comb begin
        fa_a      = fa_a_q;
        fa_b      = fa_b_q;
        res_count = res_count_q;
        res_data  = 32'h0;
        res_tag   = '0;
        if (res_valid) begin
            {res_data, res_tag} = fifo_mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// Directed bench for fpadd_stream_ctrl with a two-edge stand-in for the FP32 adder.
module tb_fpadd_stream_ctrl;

    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fa_a, fa_b, fa_out;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [15:0]      res_count;

    int checks = 0;
    int errors = 0;
    int accepts;
    int stalls;

    fpadd_stream_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .fa_a(fa_a), .fa_b(fa_b), .fa_out(fa_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_count(res_count)
    );

    always #5 clk = ~clk;

    // Adder stand-in: operands registered on one edge, sum registered on the next.
    // Only the sums the directed vectors need are modelled.
    function automatic logic [31:0] stub_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if ((a ^ b) == 32'h80000000) return 32'h00000000;
        if (a == 32'h0) return b;
        if (b == 32'h0) return a;
        return a ^ b;
    endfunction

    logic [31:0] reg_a = 32'h0, reg_b = 32'h0, sum_r = 32'h0;
    always @(posedge clk) begin
        reg_a <= fa_a;
        reg_b <= fa_b;
        sum_r <= stub_add(reg_a, reg_b);
    end
    assign fa_out = sum_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        tick();
        in_valid = 1'b0;
        check("single_fa_a", fa_a, a);
        check("single_fa_b", fa_b, b);
        tick();
        tick();
        check("single_lat2_valid", 32'(res_valid), 32'd0);
        tick();
        check("single_lat3_valid", 32'(res_valid), 32'd1);
        check("single_data", res_data, exp);
        check("single_tag", 32'(res_tag), 32'(tag));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("single_popped", 32'(res_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = 32'h0; in_b = 32'h0; in_tag = '0;
        tick();
        tick();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fa_a", fa_a, 32'h0);
        reset = 1'b1;
        tick();

        // single pair, then cancellation and zero operand
        run_single(32'h3F800000, 32'h40000000, 4'd3, 32'h40400000);
        check("single_count", 32'(res_count), 32'd1);
        run_single(32'h40400000, 32'hC0400000, 4'd9, 32'h00000000);
        run_single(32'h00000000, 32'h41200000, 4'd12, 32'h41200000);
        check("single_count3", 32'(res_count), 32'd3);

        // streaming: 16 back-to-back pairs with the consumer always ready
        res_ready = 1'b1;
        for (int j = 0; j < 19; j++) begin
            if (j < 16) begin
                check("stream_in_ready", 32'(in_ready), 32'd1);
                in_valid = 1'b1;
                in_a = 32'h40000000 | (32'(j) << 16);
                in_b = 32'h0;
                in_tag = TAG_W'(j);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (j >= 3) begin
                check("stream_valid", 32'(res_valid), 32'd1);
                check("stream_data", res_data, 32'h40000000 | (32'(j - 3) << 16));
                check("stream_tag", 32'(res_tag), 32'(j - 3));
            end
        end
        tick();
        check("stream_drained", 32'(res_valid), 32'd0);
        check("stream_count", 32'(res_count), 32'd19);

        // backpressure: consumer stalled, offer pairs continuously
        res_ready = 1'b0;
        accepts = 0;
        for (int j = 0; j < 14; j++) begin
            in_valid = 1'b1;
            in_a = 32'h41000000 + 32'(accepts);
            in_b = 32'h0;
            in_tag = TAG_W'(accepts);
            if (in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepts", 32'(accepts), 32'(DEPTH));
        tick();
        tick();
        tick();
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_valid_full", 32'(res_valid), 32'd1);
        check("bp_count_full", 32'(res_count), 32'd27);
        res_ready = 1'b1;
        check("bp_ready_before_pop", 32'(in_ready), 32'd0);
        for (int p = 0; p < DEPTH; p++) begin
            check("bp_pop_valid", 32'(res_valid), 32'd1);
            check("bp_pop_tag", 32'(res_tag), 32'(p));
            check("bp_pop_data", res_data, 32'h41000000 + 32'(p));
            tick();
            if (p == 0) check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        end
        check("bp_empty", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // reset while three pairs are in flight
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_a = 32'h42000000 + 32'(j);
            in_b = 32'h0;
            in_tag = TAG_W'(j + 1);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("rstmid_valid", 32'(res_valid), 32'd0);
            tick();
        end
        check("rstmid_count", 32'(res_count), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        run_single(32'h3F800000, 32'h40000000, 4'd5, 32'h40400000);
        check("rstmid_count1", 32'(res_count), 32'd1);

        // counter wrap: 65534 more results reach 0xFFFF, one more wraps to zero
        res_ready = 1'b1;
        stalls = 0;
        in_a = 32'h3F000000; in_b = 32'h0; in_tag = 4'd6;
        in_valid = 1'b1;
        for (int n = 0; n < 65534; n++) begin
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("wrap_stalls", 32'(stalls), 32'd0);
        check("wrap_count_max", 32'(res_count), 32'h0000FFFF);
        check("wrap_empty", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
        run_single(32'h00000000, 32'h41200000, 4'd7, 32'h41200000);
        check("wrap_count_zero", 32'(res_count), 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
